monolith_axis_m31_reducer: RTL and testbench

- Upstream stage in front of the hash IP's AXI-Stream slave input.
- Takes raw 32-bit words from the DMA and reduces each word to a canonical Mersenne-31 field element (p = 2^31-1).
- Reframes the stream into exact PERM_SIZE-beat permutation packets, with TLAST regenerated on the last beat. Pads short packets and flags framing errors.
- Registered, 2-deep skid-buffered output, so full throughput is kept under backpressure.

---
 rtl/monolith_axis_m31_reducer.sv | 100 ++++++++++
 tb/tb_monolith_axis_m31_reducer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/monolith_axis_m31_reducer.sv
// monolith_axis_m31_reducer: reduces 32-bit words mod 2^31-1 and reframes them into PERM_SIZE-beat packets.
// Optional packet counter on perm_count when MONOLITH_M31_PERM_COUNT_EN is defined.
module monolith_axis_m31_reducer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 31,
    parameter int PERM_SIZE = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic                              err_early_last,
    output logic                              err_missing_last,
    input  logic                              err_clear,
    output logic [31:0]                       perm_count
);
    localparam int CW = $clog2(PERM_SIZE);
    localparam logic [CW-1:0] LAST = CW'(PERM_SIZE - 1);
    localparam logic [31:0] P = 32'h7FFF_FFFF;
    typedef enum logic {PASS, PAD} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d, red, wr_data;
    logic out_vld_q, out_vld_d, out_last_q, out_last_d, skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
    logic rdy_q, rdy_d, early_q, early_d, miss_q, miss_d;
    logic [31:0] sum;
    logic acc, wr, wr_last, out_free, early_set, miss_set;
    always_comb begin
        sum = {1'b0, s00_axis_tdata[30:0]} + {31'b0, s00_axis_tdata[31]};
        red = sum >= P ? C_M00_AXIS_TDATA_WIDTH'(sum - P) : sum[30:0];
        acc = s00_axis_tvalid & rdy_q;
        // Pad beats only need a free slot; the skid register is the limiting slot.
        wr = state_q == PASS ? acc : !skid_vld_q;
        wr_data = state_q == PASS ? red : '0;
        wr_last = cnt_q == LAST;
        cnt_d = wr ? (wr_last ? '0 : cnt_q + 1'b1) : cnt_q;
        early_set = state_q == PASS && acc && s00_axis_tlast && !wr_last;
        miss_set = state_q == PASS && acc && wr_last && !s00_axis_tlast;
        state_d = early_set ? PAD : (state_q == PAD && wr && wr_last) ? PASS : state_q;
        out_free = !out_vld_q | m00_axis_tready;
        out_vld_d = skid_vld_q | wr | (out_vld_q & !m00_axis_tready);
        out_data_d = !out_free ? out_data_q : skid_vld_q ? skid_data_q : wr ? wr_data : out_data_q;
        out_last_d = !out_free ? out_last_q : skid_vld_q ? skid_last_q : wr ? wr_last : out_last_q;
        skid_vld_d = skid_vld_q ? !out_free : (wr & !out_free);
        skid_data_d = (!skid_vld_q && wr && !out_free) ? wr_data : skid_data_q;
        skid_last_d = (!skid_vld_q && wr && !out_free) ? wr_last : skid_last_q;
        rdy_d = !skid_vld_d && state_d == PASS;
        early_d = early_set | (early_q & !err_clear);
        miss_d = miss_set | (miss_q & !err_clear);
    end
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= PASS;
            cnt_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q <= 1'b0;
            early_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_vld_q <= out_vld_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_vld_q <= skid_vld_d;
            rdy_q <= rdy_d;
            early_q <= early_d;
            miss_q <= miss_d;
        end
    end
    assign s00_axis_tready = rdy_q;
    assign m00_axis_tvalid = out_vld_q;
    assign m00_axis_tdata = out_data_q;
    assign m00_axis_tlast = out_last_q;
    assign err_early_last = early_q;
    assign err_missing_last = miss_q;
`ifdef MONOLITH_M31_PERM_COUNT_EN
    logic [31:0] pc_q;
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) pc_q <= '0;
        else if (out_vld_q && m00_axis_tready && out_last_q) pc_q <= pc_q + 32'd1;
    end
    assign perm_count = pc_q;
`else
    assign perm_count = '0;
`endif
endmodule

// File: tb/tb_monolith_axis_m31_reducer.sv
// tb_monolith_axis_m31_reducer: random-stimulus bench against a stream-level mod-p framing model.
module tb_monolith_axis_m31_reducer;
    localparam int PS = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    logic s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [31:0] s_data = '0;
    logic m_valid, m_ready = 1'b1, m_last;
    logic [30:0] m_data;
    logic e_early, e_miss, e_clear = 1'b0;
    logic [31:0] pcount;
    int checks = 0, fails = 0, stalls = 0, perm_exp = 0, pos = 0;
    logic exp_early = 1'b0, exp_miss = 1'b0, rand_rdy = 1'b0;
    logic [31:0] exp_q[$];

    monolith_axis_m31_reducer #(.PERM_SIZE(PS)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_valid), .s00_axis_tready(s_ready),
        .s00_axis_tdata(s_data), .s00_axis_tlast(s_last),
        .m00_axis_tvalid(m_valid), .m00_axis_tready(m_ready),
        .m00_axis_tdata(m_data), .m00_axis_tlast(m_last),
        .err_early_last(e_early), .err_missing_last(e_miss),
        .err_clear(e_clear), .perm_count(pcount));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [30:0] modp(input logic [31:0] w);
        longint unsigned v = longint'(w) % 64'h7FFF_FFFF;
        return v[30:0];
    endfunction

    function automatic void model_push(input logic [31:0] w, input logic l);
        exp_q.push_back({pos == PS - 1, modp(w)});
        if (pos == PS - 1) begin
            if (!l) exp_miss = 1'b1;
            pos = 0;
        end else if (l) begin
            exp_early = 1'b1;
            for (int k = pos + 1; k < PS; k++) exp_q.push_back({k == PS - 1, 31'd0});
            pos = 0;
        end else pos++;
    endfunction

    function automatic int exp_pcount();
`ifdef MONOLITH_M31_PERM_COUNT_EN
        return perm_exp;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) m_ready = 1'b1;
        else begin
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'(m_valid), 64'd0);
                else begin
                    chk("beat", 64'({m_last, m_data}), 64'(exp_q[0]));
                    if (m_ready) begin
                        if (exp_q[0][31]) perm_exp++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data = w;
        s_last = l;
        while (!s_ready && n < 200) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
        else model_push(w, l);
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("idle_valid", 64'(m_valid), 64'd0);
    endtask

    task automatic clear_pulse();
        e_clear = 1'b1;
        exp_early = 1'b0;
        exp_miss = 1'b0;
        @(negedge clk);
        e_clear = 1'b0;
        chk("clr_early", 64'(e_early), 64'd0);
        chk("clr_miss", 64'(e_miss), 64'd0);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_early"}, 64'(e_early), 64'(exp_early));
        chk({tag, "_miss"}, 64'(e_miss), 64'(exp_miss));
        chk({tag, "_pcount"}, 64'(pcount), 64'(exp_pcount()));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, 64'(s_ready), 64'd0);
        chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
        chk({tag, "_mdata"}, 64'(m_data), 64'd0);
        chk({tag, "_mlast"}, 64'(m_last), 64'd0);
        chk({tag, "_early"}, 64'(e_early), 64'd0);
        chk({tag, "_miss"}, 64'(e_miss), 64'd0);
        chk({tag, "_pcount"}, 64'(pcount), 64'd0);
    endtask

    initial begin
        logic [31:0] corner [4];
        corner[0] = 32'h7FFF_FFFF;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFE;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1 chk("tready_before_edge", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("tready_after_edge", 64'(s_ready), 64'd1);

        stalls = 0;
        for (int i = 0; i < PS; i++) send(32'(i), i == PS - 1);
        drain();
        chk("t1_stalls", 64'(stalls), 64'd0);
        check_flags("t1");

        for (int i = 0; i < PS; i++) send(i < 4 ? corner[i] : $urandom, i == PS - 1);
        drain();
        check_flags("t2");

        for (int i = 0; i < 6; i++) send($urandom, i == 5);
        chk("pad_tready0", 64'(s_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("pad_tready1", 64'(s_ready), 64'd0);
        drain();
        check_flags("t3");
        clear_pulse();

        for (int i = 0; i < 20; i++) send($urandom, 1'b0);
        drain();
        check_flags("t4a");
        for (int i = 4; i < PS; i++) send($urandom, i == PS - 1);
        drain();
        check_flags("t4b");
        clear_pulse();

        for (int i = 0; i < PS - 1; i++) send($urandom, 1'b0);
        e_clear = 1'b1;
        send($urandom, 1'b0);
        e_clear = 1'b0;
        drain();
        check_flags("setwins");
        clear_pulse();

        rand_rdy = 1'b1;
        for (int i = 0; i < 4 * PS; i++) send($urandom, (i % PS) == PS - 1);
        drain();
        rand_rdy = 1'b0;
        check_flags("t5");

        for (int i = 0; i < 7; i++) send($urandom, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        pos = 0;
        perm_exp = 0;
        exp_early = 1'b0;
        exp_miss = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stalls = 0;
        for (int i = 0; i < PS; i++) send($urandom, i == PS - 1);
        drain();
        chk("t6_stalls", 64'(stalls), 64'd0);
        check_flags("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
